// File: rtl/fc_pkg.sv
// Shared parameters, feature type and read-FSM state encoding for the FC feeder.
// FC_FEEDER_PINGPONG_EN selects two feature banks instead of one.
package fc_pkg;
    localparam int FC_LEN     = 121;
    localparam int FEAT_W     = 23;
    localparam int NUM_CH     = 3;
    localparam int GAP_CYCLES = 2;
    localparam int IDX_W      = 7;
    localparam int GAP_W      = $clog2(GAP_CYCLES + 1);
`ifdef FC_FEEDER_PINGPONG_EN
    localparam int NUM_BANKS  = 2;
`else
    localparam int NUM_BANKS  = 1;
`endif

    typedef logic signed [FEAT_W-1:0] feat_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP
    } rd_state_t;
endpackage

// File: rtl/fc_feat_bank.sv
// Three-channel, FC_LEN-deep feature bank: one write port, one synchronous read port.
// The read register holds its value when no read is issued and doubles as the beat data register.
module fc_feat_bank
    import fc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  feat_t            wr_data [NUM_CH],
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_addr,
    output feat_t            rd_data [NUM_CH]
);
    feat_t mem [NUM_CH][FC_LEN];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mem[c][wr_addr] <= wr_data[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rd_data[c] <= '0;
            end
        end else if (rd_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rd_data[c] <= mem[c][rd_addr];
            end
        end
    end
endmodule

// File: rtl/fc_feeder.sv
// FC feeder: buffers three ReLU feature maps and streams them as FC_LEN parallel beats.
// FC_FEEDER_PINGPONG_EN enables a second bank so filling overlaps streaming.
//
//   state  | meaning
//   IDLE   | waiting for a full read bank and fc_ready
//   STREAM | issuing one bank read per cycle with fc_ready high
//   GAP    | GAP_CYCLES idle cycles so neurons can emit fc_out and re-arm
module fc_feeder
    import fc_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  wr_valid,
    output logic  wr_ready,
    input  feat_t wr_data_1,
    input  feat_t wr_data_2,
    input  feat_t wr_data_3,
    input  logic  fc_ready,
    output logic  valid_out,
    output feat_t relu_out_1,
    output feat_t relu_out_2,
    output feat_t relu_out_3,
    output logic  frame_done,
    output logic  busy
);
    rd_state_t        state;
    logic [IDX_W-1:0] widx;
    logic [IDX_W-1:0] ridx;
    logic [GAP_W-1:0] gap_cnt;
    logic [NUM_BANKS-1:0] full;
    logic             wr_bank;
    logic             rd_bank;
    logic             wr_fire;
    logic             wr_last;
    logic             issue;
    logic             rd_last;
    feat_t            wr_data [NUM_CH];
    feat_t            rd_data [NUM_BANKS][NUM_CH];

    assign wr_data[0] = wr_data_1;
    assign wr_data[1] = wr_data_2;
    assign wr_data[2] = wr_data_3;

    assign wr_ready = !full[wr_bank] && !rst;
    assign wr_fire  = wr_valid && wr_ready;
    assign wr_last  = wr_fire && (widx == IDX_W'(FC_LEN - 1));
    assign issue    = (state == STREAM) && fc_ready;
    assign rd_last  = issue && (ridx == IDX_W'(FC_LEN - 1));
    assign busy     = (state != IDLE);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        fc_feat_bank u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_fire && (wr_bank == 1'(b))),
            .wr_addr (widx),
            .wr_data (wr_data),
            .rd_en   (issue && (rd_bank == 1'(b))),
            .rd_addr (ridx),
            .rd_data (rd_data[b])
        );
    end

    // Set and clear never target the same bank: a full bank refuses writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            widx <= '0;
            full <= '0;
        end else begin
            if (wr_fire) begin
                widx <= wr_last ? '0 : widx + IDX_W'(1);
            end
            if (wr_last) begin
                full[wr_bank] <= 1'b1;
            end
            if (rd_last) begin
                full[rd_bank] <= 1'b0;
            end
        end
    end

`ifdef FC_FEEDER_PINGPONG_EN
    logic out_bank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            out_bank <= 1'b0;
        end else begin
            if (wr_last) begin
                wr_bank <= ~wr_bank;
            end
            if (rd_last) begin
                rd_bank <= ~rd_bank;
            end
            if (issue) begin
                out_bank <= rd_bank;
            end
        end
    end

    assign relu_out_1 = rd_data[out_bank][0];
    assign relu_out_2 = rd_data[out_bank][1];
    assign relu_out_3 = rd_data[out_bank][2];
`else
    assign wr_bank    = 1'b0;
    assign rd_bank    = 1'b0;
    assign relu_out_1 = rd_data[0][0];
    assign relu_out_2 = rd_data[0][1];
    assign relu_out_3 = rd_data[0][2];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ridx       <= '0;
            gap_cnt    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= issue;
            frame_done <= rd_last;
            case (state)
                IDLE: begin
                    if (full[rd_bank] && fc_ready) begin
                        state <= STREAM;
                        ridx  <= '0;
                    end
                end
                STREAM: begin
                    if (issue) begin
                        if (rd_last) begin
                            state   <= GAP;
                            ridx    <= '0;
                            gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                        end else begin
                            ridx <= ridx + IDX_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_feeder.sv
// Self-checking bench for fc_feeder: frame scoreboard plus beat-timing rules derived from the
// feeder's externally visible behaviour, with directed and randomized frames.
module tb_fc_feeder;
    import fc_pkg::*;

    localparam int LEN = 121;
    localparam int GAP = 2;
`ifdef FC_FEEDER_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  wr_valid = 1'b0;
    logic  wr_ready;
    feat_t wr_data_1 = '0;
    feat_t wr_data_2 = '0;
    feat_t wr_data_3 = '0;
    logic  fc_ready = 1'b0;
    logic  valid_out;
    feat_t relu_out_1;
    feat_t relu_out_2;
    feat_t relu_out_3;
    logic  frame_done;
    logic  busy;

    fc_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data_1  (wr_data_1),
        .wr_data_2  (wr_data_2),
        .wr_data_3  (wr_data_3),
        .fc_ready   (fc_ready),
        .valid_out  (valid_out),
        .relu_out_1 (relu_out_1),
        .relu_out_2 (relu_out_2),
        .relu_out_3 (relu_out_3),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int     n_chk = 0;
    int     n_pass = 0;
    int     exp1[$];
    int     exp2[$];
    int     exp3[$];
    longint fsum_q[$];
    longint wsum = 0;
    longint osum = 0;
    int     wk = 0;
    int     completed = 0;
    int     released = 0;
    int     writes_total = 0;
    int     beat_idx = 0;
    int     cyc = 0;
    int     last_wr_cyc = 0;
    bit     prev_fr = 1'b0;
    int     gap_run = 0;
    bit     seen_frame = 1'b0;
    bit     lat_chk = 1'b0;
    bit     gap_exact_arm = 1'b0;
    bit     gap_exact_next = 1'b0;
    int     mid_idle = 0;
    int     last1 = 0;
    int     last2 = 0;
    int     last3 = 0;
    int     mode = 0;
    feat_t  p1, p2, p3;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic gen_pending();
        if (mode == 0) begin
            p1 = FEAT_W'(wk);
            p2 = FEAT_W'(1000 + wk);
            p3 = FEAT_W'(-wk);
        end else begin
            p1 = FEAT_W'($urandom());
            p2 = FEAT_W'($urandom());
            p3 = FEAT_W'($urandom());
        end
    endtask

    task automatic monitor();
        bit in_frame;
        in_frame = (beat_idx != 0);
        if (in_frame || valid_out) chk("beat_vs_fc_ready", valid_out, prev_fr);
        if (in_frame) chk("busy_in_frame", busy, 1);
        if (valid_out) begin
            if (exp1.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                if (beat_idx == 0) begin
                    if (seen_frame) begin
                        chk("gap_min", gap_run >= GAP + 1, 1);
                        if (gap_exact_next) chk("gap_exact", gap_run, GAP + 1);
                    end
                    gap_exact_next = 1'b0;
                    if (lat_chk) begin
                        chk("first_beat_latency", cyc - last_wr_cyc, 3);
                        lat_chk = 1'b0;
                    end
                    mid_idle = 0;
                end
                chk("relu_out_1", relu_out_1, exp1[0]);
                chk("relu_out_2", relu_out_2, exp2[0]);
                chk("relu_out_3", relu_out_3, exp3[0]);
                chk("frame_done", frame_done, beat_idx == LEN - 1);
                osum += longint'(relu_out_1) + longint'(relu_out_2) + longint'(relu_out_3);
                last1 = int'(relu_out_1);
                last2 = int'(relu_out_2);
                last3 = int'(relu_out_3);
                void'(exp1.pop_front());
                void'(exp2.pop_front());
                void'(exp3.pop_front());
                if (beat_idx == LEN - 1) begin
                    released++;
                    chk("busy_at_done", busy, 1);
                    if (fsum_q.size() != 0) chk("fc_out_sum", osum, fsum_q.pop_front());
                    else chk("fc_out_sum_missing", 1, 0);
                    osum = 0;
                    beat_idx = 0;
                    seen_frame = 1'b1;
                    gap_run = 0;
                    gap_exact_next = gap_exact_arm;
                end else begin
                    beat_idx++;
                end
            end
        end else begin
            chk("frame_done_idle", frame_done, 0);
            chk("hold_relu_1", relu_out_1, last1);
            chk("hold_relu_2", relu_out_2, last2);
            chk("hold_relu_3", relu_out_3, last3);
            if (in_frame) mid_idle++;
            else gap_run++;
        end
        chk("wr_ready", wr_ready, (completed - released) < NB);
    endtask

    task automatic cycle(input bit want_wr, input bit fr);
        @(negedge clk);
        monitor();
        wr_valid  = want_wr;
        fc_ready  = fr;
        wr_data_1 = p1;
        wr_data_2 = p2;
        wr_data_3 = p3;
        if (want_wr && wr_ready) begin
            exp1.push_back(int'(p1));
            exp2.push_back(int'(p2));
            exp3.push_back(int'(p3));
            wsum += longint'(p1) + longint'(p2) + longint'(p3);
            writes_total++;
            wk++;
            if (wk == LEN) begin
                wk = 0;
                completed++;
                last_wr_cyc = cyc;
                fsum_q.push_back(wsum);
                wsum = 0;
            end
            gen_pending();
        end
        prev_fr = fr;
        cyc++;
    endtask

    task automatic write_frames(input int nframes);
        int target;
        int t;
        target = writes_total + nframes * LEN;
        for (t = 0; writes_total < target && t < 6000; t++) cycle(1'b1, 1'b1);
        chk("write_frames_count", writes_total, target);
    endtask

    task automatic drain();
        int t;
        for (t = 0; (exp1.size() != 0 || busy) && t < 3000; t++) cycle(1'b0, 1'b1);
        chk("drain_timeout", t < 3000, 1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
    endtask

    task automatic reset_checks(input string phase);
        chk({phase, "_valid_out"}, valid_out, 0);
        chk({phase, "_relu_out_1"}, relu_out_1, 0);
        chk({phase, "_relu_out_2"}, relu_out_2, 0);
        chk({phase, "_relu_out_3"}, relu_out_3, 0);
        chk({phase, "_frame_done"}, frame_done, 0);
        chk({phase, "_busy"}, busy, 0);
        chk({phase, "_wr_ready"}, wr_ready, 0);
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        reset_checks("midframe_rst");
        exp1.delete();
        exp2.delete();
        exp3.delete();
        fsum_q.delete();
        wsum = 0;
        osum = 0;
        wk = 0;
        completed = 0;
        released = 0;
        beat_idx = 0;
        seen_frame = 1'b0;
        gap_run = 0;
        last1 = 0;
        last2 = 0;
        last3 = 0;
        lat_chk = 1'b0;
        gap_exact_next = 1'b0;
        wr_valid = 1'b0;
        fc_ready = 1'b0;
        prev_fr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        gen_pending();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        reset_checks("reset");
        rst = 1'b0;

        // Directed frame with fc_ready high: latency, data order and frame_done.
        mode = 0;
        gen_pending();
        lat_chk = 1'b1;
        write_frames(1);
        drain();

        // Same frame, fc_ready dropped for 5 cycles at beat 40.
        write_frames(1);
        for (t = 0; beat_idx < 40 && t < 1000; t++) cycle(1'b0, 1'b1);
        chk("stall_reach_beat40", beat_idx, 40);
        repeat (5) cycle(1'b0, 1'b0);
        drain();
        chk("stall_idle_cycles", mid_idle, 5);

        // Two back-to-back random frames with continuous writes.
        mode = 1;
        gen_pending();
        gap_exact_arm = (NB == 2);
        write_frames(2);
        drain();
        gap_exact_arm = 1'b0;
        gap_exact_next = 1'b0;

        // Random write and fc_ready activity over three frames.
        begin
            int target;
            target = writes_total + 3 * LEN;
            for (t = 0; writes_total < target && t < 8000; t++)
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
            chk("random_writes_count", writes_total, target);
        end
        drain();

        // Asynchronous reset at beat 60, then a fresh directed frame.
        mode = 0;
        gen_pending();
        write_frames(1);
        for (t = 0; beat_idx < 60 && t < 1000; t++) cycle(1'b1, 1'b1);
        chk("reach_beat60", beat_idx, 60);
        async_reset();
        lat_chk = 1'b1;
        write_frames(1);
        drain();

        chk("scoreboard_empty", exp1.size(), 0);
        chk("frames_released", released, completed);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
